// File: rtl/alu_issue_ctrl.sv
// Issue controller for alu_32: accepts one decoded operation, pulses start,
// waits for finished (or times out) and holds the classified response for writeback.
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4:0]             req_control,
  input  logic [31:0]            req_a,
  input  logic [31:0]            req_b,
  input  logic [4:0]             req_dest,
  output logic                   alu_start,
  output logic [4:0]             alu_control,
  output logic [31:0]            alu_input_a,
  output logic [31:0]            alu_input_b,
  input  logic                   alu_finished,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_cout,
  input  logic                   alu_err_overflow,
  input  logic                   alu_err_invalid_control,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [4:0]             rsp_dest,
  output logic                   rsp_zero,
  output logic                   rsp_cout,
  output logic [1:0]             rsp_exc,
  output logic [COUNT_WIDTH-1:0] ops_completed,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while valid is
  // high and ready is low.

  // Encoding is visible on dbg_state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_OVERFLOW = 2'b01;
  localparam logic [1:0] EXC_INVALID  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  // The counter holds the number of WAIT cycles already spent, so the last
  // allowed WAIT cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt_q;
  logic [4:0] dest_q;

  logic       accept;
  logic       capture;
  logic       timeout;
  logic       rsp_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final allowed cycle beats the timeout.
        if (alu_finished) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      dest_q        <= '0;
      alu_control   <= '0;
      alu_input_a   <= '0;
      alu_input_b   <= '0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_cout      <= 1'b0;
      rsp_exc       <= EXC_NONE;
      ops_completed <= '0;
    end else begin
      if (accept) begin
        alu_control <= req_control;
        alu_input_a <= req_a;
        alu_input_b <= req_b;
        dest_q      <= req_dest;
      end

      if (state_q == S_ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end

      if (capture) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_cout   <= alu_cout;
        if (alu_err_invalid_control) begin
          rsp_exc <= EXC_INVALID;
        end else if (alu_err_overflow) begin
          rsp_exc <= EXC_OVERFLOW;
        end else begin
          rsp_exc <= EXC_NONE;
        end
      end else if (timeout) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_cout   <= 1'b0;
        rsp_exc    <= EXC_TIMEOUT;
      end

      // Wraps silently at 2^COUNT_WIDTH.
      if (rsp_done) begin
        ops_completed <= ops_completed + COUNT_WIDTH'(1);
      end
    end
  end

  assign rsp_dest  = dest_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural alu_32 responder with programmable latency,
// directed cases followed by randomized operations checked against a reference model.
module tb_alu_issue_ctrl;

  localparam int T  = 8;
  localparam int CW = 16;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_control;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic [4:0]    req_dest;
  logic          alu_start;
  logic [4:0]    alu_control;
  logic [31:0]   alu_input_a;
  logic [31:0]   alu_input_b;
  logic          alu_finished;
  logic [31:0]   alu_result;
  logic          alu_zero;
  logic          alu_cout;
  logic          alu_err_overflow;
  logic          alu_err_invalid_control;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_result;
  logic [4:0]    rsp_dest;
  logic          rsp_zero;
  logic          rsp_cout;
  logic [1:0]    rsp_exc;
  logic [CW-1:0] ops_completed;
  logic [1:0]    dbg_state;

  int tests_run = 0;
  int n_fail    = 0;
  int exp_ops   = 0;
  int alu_lat   = 0;   // WAIT cycles before finished; negative means never

  logic [40:0] exp_q[$];   // {dest, exc, zero, cout, result}

  alu_issue_ctrl #(.TIMEOUT_CYCLES(T), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_control(req_control),
    .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
    .alu_start(alu_start), .alu_control(alu_control),
    .alu_input_a(alu_input_a), .alu_input_b(alu_input_b),
    .alu_finished(alu_finished), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_err_overflow(alu_err_overflow),
    .alu_err_invalid_control(alu_err_invalid_control),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_dest(rsp_dest), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout),
    .rsp_exc(rsp_exc), .ops_completed(ops_completed), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference ALU ----------------
  // 00 AND, 01 OR, 02 signed ADD, 03 unsigned ADD, 06 signed SUB, others invalid
  // (invalid codes also raise overflow so the priority rule is exercised).
  function automatic void ref_alu(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic c,
                                  output logic o, output logic i);
    logic [32:0] wide;
    r = '0; c = 1'b0; o = 1'b0; i = 1'b0;
    case (ctrl)
      5'h00: r = a & b;
      5'h01: r = a | b;
      5'h02: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'h03: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
      end
      5'h06: begin
        wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = wide[31:0]; c = wide[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: begin
        i = 1'b1; o = 1'b1;
      end
    endcase
    z = (r == 32'd0);
  endfunction

  // Expected response from the request and how long the ALU takes.
  function automatic logic [40:0] ref_rsp(input logic [4:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] dest, input int lat);
    logic [31:0] r;
    logic z, c, o, i;
    logic [1:0] exc;
    if (lat < 0 || lat >= T) return {dest, 2'b11, 1'b0, 1'b0, 32'd0};
    ref_alu(ctrl, a, b, r, z, c, o, i);
    exc = i ? 2'b10 : (o ? 2'b01 : 2'b00);
    return {dest, exc, z, c, r};
  endfunction

  // ---------------- ALU responder ----------------
  initial begin
    int lat_l;
    logic [31:0] r;
    logic z, c, o, i;
    alu_finished = 1'b0; alu_result = '0; alu_zero = 1'b0; alu_cout = 1'b0;
    alu_err_overflow = 1'b0; alu_err_invalid_control = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (alu_start && alu_lat >= 0) begin
        lat_l = alu_lat;
        @(posedge clock); #1;
        repeat (lat_l) begin @(posedge clock); #1; end
        ref_alu(alu_control, alu_input_a, alu_input_b, r, z, c, o, i);
        alu_finished = 1'b1; alu_result = r; alu_zero = z; alu_cout = c;
        alu_err_overflow = o; alu_err_invalid_control = i;
        @(posedge clock); #1;
        alu_finished = 1'b0; alu_result = $urandom;
        alu_zero = 1'b1; alu_cout = 1'b1; alu_err_overflow = 1'b1; alu_err_invalid_control = 1'b1;
      end
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // One complete operation: request, track issue/wait, check response, hold, retire.
  task automatic do_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input int lat, input int hold);
    int n, k, exp_k, starts, start_k, opnd_bad, hold_bad;
    logic [40:0] got, exp_rsp;
    alu_lat = lat;
    req_control = ctrl; req_a = a; req_b = b; req_dest = dest; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("req_ready_wait", 64'(n < 50), 64'd1);
    step();
    req_valid = 1'b0;
    req_control = 5'($urandom); req_a = $urandom; req_b = $urandom;
    exp_q.push_back(ref_rsp(ctrl, a, b, dest, lat));
    exp_k = (lat >= 0 && lat < T) ? lat + 3 : T + 2;
    k = 1; starts = 0; start_k = 0; opnd_bad = 0;
    while (!rsp_valid && k < 300) begin
      if (alu_start) begin starts++; start_k = k; end
      if (alu_input_a !== a || alu_input_b !== b || alu_control !== ctrl) opnd_bad++;
      step(); k++;
    end
    check("rsp_latency", 64'(k), 64'(exp_k));
    check("start_pulses", 64'(starts), 64'd1);
    check("start_cycle", 64'(start_k), 64'd1);
    check("operands_held", 64'(opnd_bad), 64'd0);
    got = {rsp_dest, rsp_exc, rsp_zero, rsp_cout, rsp_result};
    exp_rsp = exp_q.pop_front();
    check("rsp_fields", 64'(got), 64'(exp_rsp));
    hold_bad = 0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      step();
      if ({rsp_dest, rsp_exc, rsp_zero, rsp_cout, rsp_result} !== got) hold_bad++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || alu_start !== 1'b0) hold_bad++;
    end
    if (hold > 0) check("rsp_hold_stable", 64'(hold_bad), 64'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_ops++;
    check("ops_completed", 64'(ops_completed), 64'(exp_ops));
    check("idle_after_rsp", {62'd0, rsp_valid, req_ready}, 64'b01);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k, hs_cnt, hs_bad, last_hs, sel, lat, bad;
    logic [4:0] codes [6];
    codes = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h06, 5'h0F};
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_control = '0; req_a = '0; req_b = '0; req_dest = '0;
    repeat (3) step();
    reset = 1'b0;

    // reset values
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_alu_start", 64'(alu_start), 64'd0);
    check("rst_alu_regs", {27'd0, alu_control, alu_input_a}, 64'd0);
    check("rst_alu_b", 64'(alu_input_b), 64'd0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_dest, rsp_exc, rsp_zero, rsp_cout, rsp_result}, 64'd0);
    check("rst_ops", 64'(ops_completed), 64'd0);

    // reset during WAIT drops the operation; the late finished is ignored
    alu_lat = 5;
    req_control = 5'h02; req_a = 32'd10; req_b = 32'd20; req_dest = 5'd9; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    k = 1;
    while (k < 4) begin step(); k++; end
    check("pre_reset_in_wait", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_wait_idle", {60'd0, dbg_state, req_ready, alu_start}, {60'd0, 2'd0, 1'b1, 1'b0});
    check("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    bad = 0;
    repeat (8) begin
      step();
      if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || alu_start !== 1'b0) bad++;
    end
    check("late_finish_ignored", 64'(bad), 64'd0);
    check("rst_wait_ops", 64'(ops_completed), 64'd0);

    // directed operations
    do_op(5'h00, 32'h0000FF00, 32'h000000FF, 5'd3, 1, 0);
    do_op(5'h02, 32'h7FFFFFFF, 32'h00000001, 5'd4, 0, 0);
    do_op(5'h06, 32'd4321, 32'd1234, 5'd5, 2, 0);
    do_op(5'h0F, 32'd1, 32'd1, 5'd6, 3, 0);
    do_op(5'h03, 32'hFFFFFFFF, 32'h00000001, 5'd7, 0, 0);
    do_op(5'h01, 32'h12340000, 32'h00005678, 5'd8, -1, 0);  // timeout
    do_op(5'h02, 32'h80000000, 32'h80000000, 5'd10, T - 1, 0);  // finish on last cycle
    do_op(5'h00, 32'hFFFFFFFF, 32'hA5A5A5A5, 5'd11, T, 0);  // finish one cycle too late
    do_op(5'h01, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd12, 1, 5);  // writeback stall

    // back-to-back with rsp_ready held high
    alu_lat = 0;
    rsp_ready = 1'b1;
    req_control = 5'h01; req_a = 32'h1; req_b = 32'h2; req_dest = 5'd1; req_valid = 1'b1;
    hs_cnt = 0; hs_bad = 0; last_hs = -4;
    for (int c = 0; c < 24; c++) begin
      if (req_valid && req_ready) begin
        if (c - last_hs != 4) hs_bad++;
        last_hs = c;
        hs_cnt++;
      end
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();
    rsp_ready = 1'b0;
    exp_ops += 6;
    check("b2b_handshakes", 64'(hs_cnt), 64'd6);
    check("b2b_interval", 64'(hs_bad), 64'd0);
    check("b2b_ops", 64'(ops_completed), 64'(exp_ops));

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 5);
      lat = $urandom_range(0, T + 1);
      if (lat == T + 1) lat = -1;
      do_op(codes[sel], ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom,
            5'($urandom), lat, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
